// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - IR fields, ALU flags and control outputs between datapath and controller
//
// Purpose: bundles the instruction-register fields and ALU flags fed to the
// controller together with every select / enable it returns to the datapath.
// Ports (signals):
//   Cond[3:0], Op[1:0], Funct[5:0], Rd[3:0]  IR fields (datapath -> controller)
//   ALUFlags[3:0]                            {N,Z,C,V} from the ALU, current cycle
//   PCWrite, MemWrite, RegWrite, IRWrite     gated write enables
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB      datapath selects
//   ImmSrc, RegSrc, ALUControl               extender / regfile / ALU control
//   State[3:0]                               current FSM state for debug
// Modports: master = datapath side, slave = controller side.

interface multicycle_controller_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;
  logic [3:0] State;

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, State
  );

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle ARM control unit: FSM, ALU decode, NZCV flags, conditional execution
//
// Purpose: sequences each instruction through fetch/decode/execute/memory/
// writeback (3-5 clocks), drives all datapath selects and enables, and owns
// the NZCV flags register plus the condition check.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   ctl    multicycle_controller_if.slave (IR fields, ALU flags in; controls out)

module multicycle_controller (
  input  logic                         clk,
  input  logic                         reset,
  multicycle_controller_if.slave       ctl
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     state, next_state;
  logic [3:0] flags;        // {N,Z,C,V}
  logic       condexreg;

  // Raw (ungated) per-state controls
  logic       next_pc, branch, regw, memw, irwrite_raw, aluop;
  logic       adrsrc, alusrca;
  logic [1:0] resultsrc, alusrcb;

  logic [1:0] alucontrol, flagw;
  logic       condex, rd15;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = FETCH;
    next_pc     = 1'b0;
    branch      = 1'b0;
    regw        = 1'b0;
    memw        = 1'b0;
    irwrite_raw = 1'b0;
    aluop       = 1'b0;
    adrsrc      = 1'b0;
    alusrca     = 1'b0;
    resultsrc   = 2'b00;
    alusrcb     = 2'b00;
    case (state)
      FETCH: begin
        next_state  = DECODE;
        irwrite_raw = 1'b1;
        alusrca     = 1'b1;
        alusrcb     = 2'b10;
        resultsrc   = 2'b10;
        next_pc     = 1'b1;
      end
      DECODE: begin
        // PC+4 computed again here so R15 reads as PC+8
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        case (ctl.Op)
          2'b01:   next_state = MEMADR;
          2'b00:   next_state = ctl.Funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   next_state = BRANCH;
          default: next_state = FETCH;   // undefined instruction
        endcase
      end
      MEMADR: begin
        alusrcb    = 2'b01;
        next_state = ctl.Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adrsrc     = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        resultsrc = 2'b01;
        regw      = 1'b1;
      end
      MEMWR: begin
        adrsrc = 1'b1;
        memw   = 1'b1;
      end
      EXECUTER: begin
        aluop      = 1'b1;
        next_state = ALUWB;
      end
      EXECUTEI: begin
        alusrcb    = 2'b01;
        aluop      = 1'b1;
        next_state = ALUWB;
      end
      ALUWB: begin
        regw = 1'b1;
      end
      BRANCH: begin
        alusrcb   = 2'b01;
        resultsrc = 2'b10;
        branch    = 1'b1;
      end
      default: next_state = FETCH;       // illegal codes recover
    endcase
  end

  // ALU decode; unlisted Funct[4:1] fall back to ADD and so update C,V too
  always_comb begin
    alucontrol = 2'b00;
    flagw      = 2'b00;
    if (aluop) begin
      case (ctl.Funct[4:1])
        4'b0100: alucontrol = 2'b00;
        4'b0010: alucontrol = 2'b01;
        4'b0000: alucontrol = 2'b10;
        4'b1100: alucontrol = 2'b11;
        default: alucontrol = 2'b00;
      endcase
      flagw[1] = ctl.Funct[0];
      flagw[0] = ctl.Funct[0] & ~alucontrol[1];
    end
  end

  always_comb begin
    condex = 1'b0;
    case (ctl.Cond)
      4'b0000: condex = flags[2];
      4'b0001: condex = ~flags[2];
      4'b0010: condex = flags[1];
      4'b0011: condex = ~flags[1];
      4'b0100: condex = flags[3];
      4'b0101: condex = ~flags[3];
      4'b0110: condex = flags[0];
      4'b0111: condex = ~flags[0];
      4'b1000: condex = flags[1] & ~flags[2];
      4'b1001: condex = ~flags[1] | flags[2];
      4'b1010: condex = (flags[3] == flags[0]);
      4'b1011: condex = (flags[3] != flags[0]);
      4'b1100: condex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: condex = flags[2] | (flags[3] != flags[0]);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  // CondExReg is frozen after DECODE so an S-suffixed instruction's own
  // flag update cannot veto its writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags     <= 4'b0000;
      condexreg <= 1'b0;
    end else begin
      if (state == DECODE) condexreg <= condex;
      if ((state == EXECUTER || state == EXECUTEI) && condexreg) begin
        if (flagw[1]) flags[3:2] <= ctl.ALUFlags[3:2];
        if (flagw[0]) flags[1:0] <= ctl.ALUFlags[1:0];
      end
    end
  end

  assign rd15 = (ctl.Rd == 4'b1111);

  // Enables are masked by reset so nothing is written while it is held low
  assign ctl.PCWrite  = reset & (next_pc | (condexreg & (branch | (regw & rd15))));
  assign ctl.RegWrite = reset & regw & condexreg & ~rd15;
  assign ctl.MemWrite = reset & memw & condexreg;
  assign ctl.IRWrite  = reset & irwrite_raw;

  assign ctl.AdrSrc     = adrsrc;
  assign ctl.ResultSrc  = resultsrc;
  assign ctl.ALUSrcA    = alusrca;
  assign ctl.ALUSrcB    = alusrcb;
  assign ctl.ALUControl = alucontrol;
  assign ctl.ImmSrc     = ctl.Op;
  assign ctl.RegSrc     = {(ctl.Op == 2'b01), (ctl.Op == 2'b10)};
  assign ctl.State      = state;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle ARM datapath: one state machine sequences each instruction through fetch, decode, execute, memory and writeback over 3–5 clocks.
- Drives every datapath select and write enable, including ImmSrc for the immediate extender.
- Owns the NZCV flags register and conditional-execution logic.
- Sits beside the datapath; its instruction inputs come from the instruction register (IR).

Parameters:
- None. The state encoding is fixed by this document.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- Cond  input  4  IR[31:28].
- Op  input  2  IR[27:26].
- Funct  input  6  IR[25:20].
- Rd  input  4  IR[15:12].
- ALUFlags  input  4  {N,Z,C,V} from the ALU, current cycle.
- PCWrite  output  1  PC register enable.
- MemWrite  output  1  data memory write enable.
- RegWrite  output  1  register file write enable.
- IRWrite  output  1  IR load enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  1  ALU A select: 0 = RD1, 1 = PC.
- ALUSrcB  output  2  ALU B select: 00 = RD2, 01 = ExtImm, 10 = constant 4.
- ImmSrc  output  2  extender mode: 00 = DP imm8, 01 = LDR/STR imm12, 10 = branch imm24.
- RegSrc  output  2  register read-address selects.
- ALUControl  output  2  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
- State  output  4  current state, for debug and verification.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Codes 10–15 are illegal and go to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 & Funct[5]=0 -> EXECUTER; Op=00 & Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH (undefined instruction, nothing written).
  - MEMADR: Funct[0]=1 -> MEMRD, else -> MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECUTER / EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Per-state raw controls; anything unlisted is 0 / 00:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1, ADD.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ADD (R15 reads PC+8).
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ADD.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECUTER: ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1, ADD.
- Decoder outputs, valid in every state:
  - ImmSrc = Op.
  - RegSrc[0] = (Op==10).
  - RegSrc[1] = (Op==01).
- ALU decode, when ALUOp=1, on Funct[4:1]:
  - 0100 -> ADD; 0010 -> SUB; 0000 -> AND; 1100 -> ORR; any other -> ADD.
  - FlagW[1] (NZ) = Funct[0].
  - FlagW[0] (CV) = Funct[0] & (ADD or SUB).
  - When ALUOp=0: ADD and FlagW=00.
- Condition check:
  - CondEx is evaluated from Cond and the flags register using the standard ARM codes 0000 EQ through 1110 AL; 1111 evaluates false.
  - CondEx is latched into CondExReg on the edge leaving DECODE and held until the next DECODE, so a flag update in EXECUTE cannot change the outcome of its own writeback.
- Flags register:
  - In EXECUTER/EXECUTEI, if CondExReg=1, the flags update on the rising edge.
  - N,Z load from ALUFlags[3:2] when FlagW[1]=1; C,V load from ALUFlags[1:0] when FlagW[0]=1.
- Gated outputs, all combinational from state, IR fields and CondExReg:
  - PCWrite = NextPC | (CondExReg & (Branch | (RegW & Rd==1111))).
  - RegWrite = RegW & CondExReg & ~(Rd==1111). A write to R15 goes to the PC, not the register file.
  - MemWrite = MemW & CondExReg.
  - IRWrite is never gated.
- Reset (reset=0):
  - State=FETCH, flags=0000, CondExReg=0, immediately (asynchronous).
  - While reset=0, PCWrite, MemWrite, RegWrite and IRWrite are forced to 0; the selects show FETCH values.
  - The first rising edge after release performs the fetch.
  - Reset asserted mid-instruction abandons it; no partial write occurs after assertion.
- Latency: data-processing 4 cycles, LDR 5, STR 4, branch 3, undefined 2.

Test Plan:
- Reset low for 2 clocks, then release -> State=0, all write enables 0 during reset. Next cycle: State=1 and PCWrite=IRWrite=1 were seen in FETCH.
- ADDS R1,R2,#5 (Cond=1110, Op=00, Funct=101001) -> states 0,1,7,8,0. EXECUTEI: ImmSrc=00, ALUSrcB=01, ALUControl=00. ALUWB: RegWrite=1. ALUFlags=0100 loads flags to Z=1, C=V=0.
- SUBS with Z result, then NE instruction (Cond=0001) -> the NE instruction completes its state sequence with RegWrite=MemWrite=0 and PCWrite=1 only in FETCH.
- LDR (Op=01, Funct=011001) -> states 0,1,2,3,4,0. MEMRD: AdrSrc=1. MEMWB: ResultSrc=01, RegWrite=1. STR (Funct[0]=0) -> 0,1,2,5,0 with MemWrite=1 in state 5.
- B with Cond=1110 (Op=10) -> states 0,1,9,0; BRANCH: ImmSrc=10, PCWrite=1, RegSrc=01. Same instruction with Cond=0000 and Z=0 -> PCWrite=0 in BRANCH.
- Reset pulsed low during MEMWR -> MemWrite drops to 0 immediately and State=0; an Op=11 instruction returns to FETCH after DECODE with no writes.
